sar_adc_array_controller: RTL and testbench
===========================================

// Module: sar_adc_array_controller
// PURPOSE
//  N-channel SAR ADC controller that replaces the per-signal single-channel SAR controllers.
//  Converts all enabled channels in lockstep from one start pulse, sharing one run_adc_n strobe.
//  Adds a per-channel enable mask, programmable DAC settle time and 2^AVG_LOG2 oversample averaging.
//  Sits between the analog comparator/cap-DAC front ends and the deconv kernel estimator (out_valid -> *_adc_done).
// PARAMETERS
//  NUM_CH         2  number of channels converted in parallel
//  ADC_BITS       8  result width per channel
//  SETTLE_CYCLES  1  clocks each trial code is held before the comparator is sampled (>=1)
//  AVG_LOG2       0  conversions averaged per result = 2^AVG_LOG2 (0 = single conversion)
// PORTS
//  clk             in   1                 system clock
//  rst_n           in   1                 asynchronous active-low reset
//  adc_start       in   1                 start request, sampled on clk
//  ch_enable       in   NUM_CH            channel mask, captured on accepted start
//  comparator_val  in   NUM_CH            1 = Vin >= DAC trial for channel c; pre-synchronised
//  run_adc_n       out  1                 active-low conversion strobe to the analog front end
//  dac_code        out  NUM_CH*ADC_BITS   trial code per channel; ch c = [c*ADC_BITS +: ADC_BITS]
//  adc_val         out  NUM_CH*ADC_BITS   averaged result per channel; same packing as dac_code
//  out_valid       out  1                 1-cycle pulse: adc_val updated this cycle
//  busy            out  1                 conversion in progress
//  overrun         out  1                 sticky: start arrived while busy
// BEHAVIOUR
//  Reset (async, all regs): state=IDLE, run_adc_n=1, dac_code=0, adc_val=0, out_valid=0, busy=0, overrun=0, acc=0.
//  FSM states: IDLE, SAMPLE, CONVERT, ACCUM, DONE.
//  - IDLE: adc_start=1 -> SAMPLE. Capture ch_enable. Clear accumulators, conv_cnt and overrun.
//  - SAMPLE (1 cycle): run_adc_n=0, dac_code=0 -> CONVERT with bit index i=ADC_BITS-1.
//  - CONVERT: run_adc_n=0. For bit i, dac_code = result | (1<<i), held SETTLE_CYCLES cycles.
//    On the last settle cycle, comparator_val[c] is sampled: 1 keeps bit i, 0 clears it.
//    Then i decrements. After bit 0 -> ACCUM.
//  - ACCUM (1 cycle): run_adc_n=1. acc[c] += result[c] (acc width ADC_BITS+AVG_LOG2, no overflow possible).
//    If conv_cnt == 2^AVG_LOG2-1 -> DONE, else conv_cnt++ and -> SAMPLE.
//  - DONE (1 cycle): adc_val[c] = acc[c] >> AVG_LOG2 (truncating), out_valid=1 -> IDLE.
//    adc_start=1 in DONE is accepted -> SAMPLE (back-to-back, with IDLE capture actions).
//  busy=1 in SAMPLE, CONVERT and ACCUM; busy=0 in IDLE and DONE.
//  Latency: start sampled in cycle 0; out_valid in cycle 2^AVG_LOG2*(ADC_BITS*SETTLE_CYCLES+2)+1.
//  adc_val holds between out_valid pulses. dac_code returns to 0 in ACCUM, DONE and IDLE.
//  Disabled channel (captured mask bit 0): dac_code slice=0, comparator ignored, adc_val slice=0 at DONE.
//  ch_enable=0 (all channels): full sequence still runs, out_valid still fires, all adc_val=0.
//  adc_start while busy=1: ignored, sequence unaffected, overrun set; cleared only by an accepted start or reset.
//  Mid-conversion rst_n low: all outputs take reset values immediately; no out_valid is produced.
//  Comparator sense is per channel, so channels resolve different codes in the same cycles.
// TESTING
//  1. NUM_CH=2, ADC_BITS=8, S=1, AVG=0; model Vin ch0=0xA5, ch1=0x3C; pulse start
//     -> out_valid at cycle 11, adc_val={0x3C,0xA5}, run_adc_n low cycles 1..9.
//  2. Vin ch0=0xFF, ch1=0x00 -> ch0 dac_code 0x80,0xC0,...,0xFF; ch1 0x80,0x40,...,0x01; adc_val={0x00,0xFF}.
//  3. AVG_LOG2=2; ch0 Vin 100,101,102,103 across conversions -> out_valid at cycle 41, ch0 adc_val=101.
//  4. SETTLE_CYCLES=3 -> each trial code stable 3 cycles; out_valid at cycle 27; same codes as test 1.
//  5. ch_enable=2'b01 -> ch1 dac_code stays 0, ch1 adc_val=0x00, ch0 correct.
//  6. start pulsed during CONVERT -> overrun=1, result and timing unchanged.
//     Next start in DONE -> back-to-back conversion, overrun=0.
//  7. rst_n low at cycle 5 of CONVERT -> all outputs at reset values, no out_valid; next start converts correctly.

Source files
------------

// File: rtl/sar_adc_array_controller.sv
// Multi-channel SAR ADC controller.
// One shared sequencer steps every channel through the same successive-
// approximation schedule; each channel keeps its own trial/result/accumulator
// state in a sar_adc_lane instance, so channels resolve different codes in
// the same cycles. Results can be averaged over 2^AVG_LOG2 conversions.

// Per-channel datapath: trial code, decided bits, accumulator and result.
module sar_adc_lane #(
    parameter int ADC_BITS = 8,
    parameter int AVG_LOG2 = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,          // captured channel enable
    input  logic                comp,        // 1 = Vin >= current trial code
    input  logic                clr_acc,     // accepted start: clear accumulator
    input  logic                clr_res,     // new conversion: clear decided bits
    input  logic                decide,      // last settle cycle of the current bit
    input  logic                accum,       // add result into accumulator
    input  logic                finish,      // final accumulate: publish average
    input  logic                in_conv_nxt, // next cycle presents a trial code
    input  logic [ADC_BITS-1:0] bit_cur,     // one-hot of bit being decided now
    input  logic [ADC_BITS-1:0] bit_nxt,     // one-hot of bit presented next cycle
    output logic [ADC_BITS-1:0] dac_code,
    output logic [ADC_BITS-1:0] adc_val
);
    localparam int AW = ADC_BITS + AVG_LOG2;

    logic [ADC_BITS-1:0] res, res_nxt, trial;
    logic [AW-1:0]       acc, acc_sum;

    // Resolve the current bit; a disabled channel never accepts a bit so it stays 0.
    always_comb begin
        trial   = res | bit_cur;
        res_nxt = res;
        if (clr_res)
            res_nxt = '0;
        else if (decide && en && comp)
            res_nxt = trial;
    end

    assign acc_sum = acc + AW'(res);

    // Decided bits, registered trial code, accumulator and averaged result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res      <= '0;
            dac_code <= '0;
            acc      <= '0;
            adc_val  <= '0;
        end else begin
            res      <= res_nxt;
            dac_code <= (in_conv_nxt && en) ? (res_nxt | bit_nxt) : '0;
            if (clr_acc)
                acc <= '0;
            else if (accum)
                acc <= acc_sum;
            // Truncating divide by 2^AVG_LOG2 is just dropping the low bits.
            if (finish)
                adc_val <= acc_sum[AW-1:AVG_LOG2];
        end
    end
endmodule

module sar_adc_array_controller #(
    parameter int NUM_CH        = 2,
    parameter int ADC_BITS      = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int AVG_LOG2      = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         adc_start,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH-1:0]            comparator_val,
    output logic                         run_adc_n,
    output logic [NUM_CH*ADC_BITS-1:0]   dac_code,
    output logic [NUM_CH*ADC_BITS-1:0]   adc_val,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);
    localparam int BW    = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;
    localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int NCONV = 1 << AVG_LOG2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SAMPLE  = 3'd1;
    localparam logic [2:0] ST_CONVERT = 3'd2;
    localparam logic [2:0] ST_ACCUM   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [ADC_BITS-1:0] ONE = ADC_BITS'(1);

    logic [2:0]        state, state_nxt;
    logic [BW-1:0]     bit_idx, bit_idx_nxt;
    logic [SW-1:0]     settle_cnt, settle_nxt;
    logic [CW-1:0]     conv_cnt, conv_nxt;
    logic [NUM_CH-1:0] en_mask;

    logic start_ok, settle_last, conv_last, seq_busy;

    logic [NUM_CH-1:0][ADC_BITS-1:0] lane_dac, lane_val;
    logic [ADC_BITS-1:0]             bit_cur_oh, bit_nxt_oh;

    assign seq_busy    = (state == ST_SAMPLE) || (state == ST_CONVERT) || (state == ST_ACCUM);
    // DONE accepts a start directly so conversions can run back to back.
    assign start_ok    = adc_start && ((state == ST_IDLE) || (state == ST_DONE));
    assign settle_last = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign conv_last   = (conv_cnt == CW'(NCONV - 1));
    assign bit_cur_oh  = ONE << bit_idx;
    assign bit_nxt_oh  = ONE << bit_idx_nxt;

    // Sequencer next-state: bit index, settle counter and conversion counter.
    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        settle_nxt  = settle_cnt;
        conv_nxt    = conv_cnt;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_nxt = ST_SAMPLE;
                    conv_nxt  = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                state_nxt   = ST_CONVERT;
                bit_idx_nxt = BW'(ADC_BITS - 1);
                settle_nxt  = '0;
            end
            ST_CONVERT: begin
                if (settle_last) begin
                    settle_nxt = '0;
                    if (bit_idx == '0)
                        state_nxt = ST_ACCUM;
                    else
                        bit_idx_nxt = bit_idx - BW'(1);
                end else begin
                    settle_nxt = settle_cnt + SW'(1);
                end
            end
            ST_ACCUM: begin
                if (conv_last) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_SAMPLE;
                    conv_nxt  = conv_cnt + CW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer state plus glitch-free registered strobes decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_idx    <= '0;
            settle_cnt <= '0;
            conv_cnt   <= '0;
            en_mask    <= '0;
            run_adc_n  <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_idx    <= bit_idx_nxt;
            settle_cnt <= settle_nxt;
            conv_cnt   <= conv_nxt;
            if (start_ok)
                en_mask <= ch_enable;
            run_adc_n  <= !((state_nxt == ST_SAMPLE) || (state_nxt == ST_CONVERT));
            busy       <= (state_nxt == ST_SAMPLE) || (state_nxt == ST_CONVERT) ||
                          (state_nxt == ST_ACCUM);
            out_valid  <= (state_nxt == ST_DONE);
            if (start_ok)
                overrun <= 1'b0;
            else if (adc_start && seq_busy)
                overrun <= 1'b1;
        end
    end

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_lane
            sar_adc_lane #(
                .ADC_BITS (ADC_BITS),
                .AVG_LOG2 (AVG_LOG2)
            ) u_lane (
                .clk         (clk),
                .rst_n       (rst_n),
                .en          (en_mask[c]),
                .comp        (comparator_val[c]),
                .clr_acc     (start_ok),
                .clr_res     (state == ST_SAMPLE),
                .decide      ((state == ST_CONVERT) && settle_last),
                .accum       (state == ST_ACCUM),
                .finish      ((state == ST_ACCUM) && conv_last),
                .in_conv_nxt (state_nxt == ST_CONVERT),
                .bit_cur     (bit_cur_oh),
                .bit_nxt     (bit_nxt_oh),
                .dac_code    (lane_dac[c]),
                .adc_val     (lane_val[c])
            );
        end
    endgenerate

    assign dac_code = lane_dac;
    assign adc_val  = lane_val;
endmodule

// File: tb/tb_sar_adc_array_controller.sv
// Bench for sar_adc_array_controller: ideal comparator front ends drive three
// instances (default, 4x averaging, 3-cycle settle). Expected codes come from
// a reference model: an ideal SAR converges to Vin, and the trial presented for
// bit i is Vin's bits above i with bit i set.
module tb_sar_adc_array_controller;
    localparam int NB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // default instance
    logic            start;
    logic [1:0]      en, comp;
    logic            run_n, ov, busy, ovr;
    logic [2*NB-1:0] dac, val;
    logic [NB-1:0]   vin [2];

    // averaging instance (AVG_LOG2=2)
    logic            a_start;
    logic [1:0]      a_en, a_comp;
    logic            a_run_n, a_ov, a_busy, a_ovr;
    logic [2*NB-1:0] a_dac, a_val;
    logic [NB-1:0]   a_vin [2];

    // settle instance (SETTLE_CYCLES=3)
    logic            s_start;
    logic [1:0]      s_en, s_comp;
    logic            s_run_n, s_ov, s_busy, s_ovr;
    logic [2*NB-1:0] s_dac, s_val;
    logic [NB-1:0]   s_vin [2];

    sar_adc_array_controller u_dut (
        .clk(clk), .rst_n(rst_n), .adc_start(start), .ch_enable(en),
        .comparator_val(comp), .run_adc_n(run_n), .dac_code(dac), .adc_val(val),
        .out_valid(ov), .busy(busy), .overrun(ovr));

    sar_adc_array_controller #(.AVG_LOG2(2)) u_avg (
        .clk(clk), .rst_n(rst_n), .adc_start(a_start), .ch_enable(a_en),
        .comparator_val(a_comp), .run_adc_n(a_run_n), .dac_code(a_dac), .adc_val(a_val),
        .out_valid(a_ov), .busy(a_busy), .overrun(a_ovr));

    sar_adc_array_controller #(.SETTLE_CYCLES(3)) u_set (
        .clk(clk), .rst_n(rst_n), .adc_start(s_start), .ch_enable(s_en),
        .comparator_val(s_comp), .run_adc_n(s_run_n), .dac_code(s_dac), .adc_val(s_val),
        .out_valid(s_ov), .busy(s_busy), .overrun(s_ovr));

    // Ideal analog front ends.
    always_comb begin
        comp   = '0;
        a_comp = '0;
        s_comp = '0;
        for (int c = 0; c < 2; c++) begin
            comp[c]   = (vin[c]   >= dac[c*NB +: NB]);
            a_comp[c] = (a_vin[c] >= a_dac[c*NB +: NB]);
            s_comp[c] = (s_vin[c] >= s_dac[c*NB +: NB]);
        end
    end

    int checks   = 0;
    int failures = 0;
    logic [2*NB-1:0] prev_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Trial code presented while bit i is being decided for input v.
    function automatic logic [NB-1:0] trial(input logic [NB-1:0] v, input int i);
        logic [31:0] hi;
        hi = (32'(v) >> (i + 1)) << (i + 1);
        return NB'(hi | (32'd1 << i));
    endfunction

    function automatic logic [NB-1:0] ref_val(input logic [NB-1:0] v, input logic e);
        return e ? v : '0;
    endfunction

    typedef struct {
        logic [NB-1:0] v0, v1;
        logic [1:0]    en;
        logic [NB-1:0] x0, x1;
    } vec_t;
    vec_t tbl [6];

    // One conversion on the default instance, checked cycle by cycle.
    // started=1: start is already high in the current cycle (back-to-back).
    task automatic do_conv(input logic [1:0] en_i, input logic [NB-1:0] v0, v1,
                           input logic [NB-1:0] x0, x1, input int ovr_at,
                           input bit b2b, input bit started, input string tag);
        int vld_at = -1;
        int bad_run = 0, bad_busy = 0, bad_dac = 0, bad_vld = 0;
        logic [NB-1:0] e;
        if (!started) @(negedge clk);
        start = 1'b1; en = en_i; vin[0] = v0; vin[1] = v1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) begin
                chk({tag, "_hold_val"}, val, prev_val);
                chk({tag, "_ovr_clr"}, ovr, 0);
            end
            if (run_n !== 1'(k > 9)) bad_run++;
            if (busy !== 1'(k <= 10)) bad_busy++;
            if (ov !== 1'(k == 11)) bad_vld++;
            if (ov === 1'b1 && vld_at < 0) vld_at = k;
            for (int c = 0; c < 2; c++) begin
                e = (k >= 2 && k <= 9 && en_i[c]) ? trial(c ? v1 : v0, 9 - k) : '0;
                if (dac[c*NB +: NB] !== e) bad_dac++;
            end
            if (k == 11) begin
                chk({tag, "_adc_val"}, val, {x1, x0});
                chk({tag, "_ovr"}, ovr, (ovr_at != 0) ? 1 : 0);
            end
            if (k == ovr_at) start = 1'b1;
            if (b2b && k == 11) begin
                start = 1'b1;
                break;
            end
        end
        chk({tag, "_vld_cycle"}, vld_at, 11);
        chk({tag, "_vld_pulse"}, bad_vld, 0);
        chk({tag, "_run_n"}, bad_run, 0);
        chk({tag, "_busy"}, bad_busy, 0);
        chk({tag, "_dac_seq"}, bad_dac, 0);
        prev_val = {x1, x0};
    endtask

    initial begin
        tbl[0] = '{8'hA5, 8'h3C, 2'b11, 8'hA5, 8'h3C};
        tbl[1] = '{8'hFF, 8'h00, 2'b11, 8'hFF, 8'h00};
        tbl[2] = '{8'hA5, 8'h3C, 2'b01, 8'hA5, 8'h00};
        tbl[3] = '{8'h00, 8'hFF, 2'b10, 8'h00, 8'hFF};
        tbl[4] = '{8'h12, 8'h34, 2'b00, 8'h00, 8'h00};
        tbl[5] = '{8'h80, 8'h7F, 2'b11, 8'h80, 8'h7F};

        rst_n = 1'b0; prev_val = '0;
        start = 0; en = 0; vin[0] = 0; vin[1] = 0;
        a_start = 0; a_en = 2'b11; a_vin[0] = 0; a_vin[1] = 0;
        s_start = 0; s_en = 2'b11; s_vin[0] = 0; s_vin[1] = 0;
        repeat (2) @(negedge clk);
        chk("rst_run_n", run_n, 1);
        chk("rst_dac", dac, 0);
        chk("rst_val", val, 0);
        chk("rst_out_valid", ov, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", ovr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // table-driven conversions
        foreach (tbl[i])
            do_conv(tbl[i].en, tbl[i].v0, tbl[i].v1, tbl[i].x0, tbl[i].x1, 0, 0, 0,
                    $sformatf("tbl%0d", i));

        // start during CONVERT sets overrun; start in DONE runs back to back
        do_conv(2'b11, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 5, 1, 0, "ovr");
        do_conv(2'b11, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 0, 0, 1, "b2b");

        // reset in the middle of CONVERT
        @(negedge clk);
        start = 1'b1; en = 2'b11; vin[0] = 8'h77; vin[1] = 8'h11;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = (k == 3);
        end
        chk("mid_ovr_before_rst", ovr, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_run_n", run_n, 1);
        chk("mid_rst_dac", dac, 0);
        chk("mid_rst_val", val, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", ovr, 0);
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (k == 3) rst_n = 1'b1;
                if (ov !== 1'b0) seen++;
            end
            chk("mid_rst_no_valid", seen, 0);
        end
        prev_val = '0;
        do_conv(2'b11, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0, 0, 0, "post_rst");

        // randomized conversions against the reference model
        for (int n = 0; n < 16; n++) begin
            logic [NB-1:0] r0, r1;
            logic [1:0] re;
            r0 = NB'($urandom);
            r1 = NB'($urandom);
            re = 2'($urandom);
            do_conv(re, r0, r1, ref_val(r0, re[0]), ref_val(r1, re[1]), 0, 0, 0,
                    $sformatf("rnd%0d", n));
        end

        // 4x averaging: ch0 100..103 -> 101, ch1 7,8,8,8 -> 7 (truncating)
        begin
            int vld_at = -1;
            logic [2*NB-1:0] got = '0;
            @(negedge clk);
            a_start = 1'b1; a_vin[0] = 8'd100; a_vin[1] = 8'd7;
            for (int k = 1; k <= 45; k++) begin
                int j;
                @(negedge clk);
                a_start = 1'b0;
                j = (k - 1) / 10;
                if (j < 4) begin
                    a_vin[0] = NB'(100 + j);
                    a_vin[1] = (j == 0) ? 8'd7 : 8'd8;
                end
                if (a_ov === 1'b1 && vld_at < 0) begin
                    vld_at = k;
                    got = a_val;
                end
            end
            chk("avg_vld_cycle", vld_at, 41);
            chk("avg_ch0", got[NB-1:0], 101);
            chk("avg_ch1", got[2*NB-1:NB], 7);
        end

        // 3-cycle settle: each trial held 3 cycles, valid at cycle 27
        begin
            int vld_at = -1, bad_dac = 0;
            logic [2*NB-1:0] got = '0;
            logic [NB-1:0] e;
            @(negedge clk);
            s_start = 1'b1; s_vin[0] = 8'hA5; s_vin[1] = 8'h3C;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
                s_start = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    e = (k >= 2 && k <= 25) ? trial(s_vin[c], 7 - (k - 2) / 3) : '0;
                    if (s_dac[c*NB +: NB] !== e) bad_dac++;
                end
                if (s_ov === 1'b1 && vld_at < 0) begin
                    vld_at = k;
                    got = s_val;
                end
            end
            chk("settle_vld_cycle", vld_at, 27);
            chk("settle_dac_seq", bad_dac, 0);
            chk("settle_val", got, {8'h3C, 8'hA5});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
